// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract, one WORD_W slice per cycle, LSB slice first. Latency NWORDS+1 cycles.
// Single operation in flight: in_ready only when idle, and the result is held while out_ready=0.
module mp_add_seq #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       sub,
    input  logic                       cin,
    input  logic [WORD_W*NWORDS-1:0]   dataa,
    input  logic [WORD_W*NWORDS-1:0]   datab,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W*NWORDS-1:0]   result,
    output logic                       cout,
    output logic                       overflow
);

    localparam int W     = WORD_W * NWORDS;
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       res_q, res_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [WORD_W-1:0]  a_sl;
    logic [WORD_W-1:0]  b_sl;
    logic [WORD_W-1:0]  b_eff;
    logic [WORD_W:0]    sum;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        // Subtraction is a + ~b + 1 with borrow-in folded into the initial carry.
        a_sl  = a_q[idx_q*WORD_W +: WORD_W];
        b_sl  = b_q[idx_q*WORD_W +: WORD_W];
        b_eff = sub_q ? ~b_sl : b_sl;
        sum   = {1'b0, a_sl} + {1'b0, b_eff} + {{WORD_W{1'b0}}, carry_q};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = dataa;
                    b_d     = datab;
                    sub_d   = sub;
                    idx_d   = '0;
                    carry_d = sub ? ~cin : cin;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[idx_q*WORD_W +: WORD_W] = sum[WORD_W-1:0];
                carry_d = sum[WORD_W];
                if (idx_q == LAST) begin
                    cout_d  = sum[WORD_W];
                    // Carry into the MSB is recovered from the MSB's own sum bit.
                    ovf_d   = a_sl[WORD_W-1] ^ b_eff[WORD_W-1] ^ sum[WORD_W-1] ^ sum[WORD_W];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed-vector bench for mp_add_seq at default parameters (4 x 32-bit slices).
module tb_mp_add_seq;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic         sub;
    logic         cin;
    logic [127:0] dataa;
    logic [127:0] datab;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result;
    logic         cout;
    logic         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    mp_add_seq dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .cin       (cin),
        .dataa     (dataa),
        .datab     (datab),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request from IDLE, wait for out_valid, capture, then handshake.
    task automatic run_op(input logic s, input logic c, input logic [127:0] a, input logic [127:0] b,
                          output logic [127:0] r, output logic co, output logic ov, output int lat);
        sub = s; cin = c; dataa = a; datab = b; in_valid = 1'b1; out_ready = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
            in_valid = 1'b0;
        end while (!out_valid && lat < 20);
        r = result; co = cout; ov = overflow;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [127:0] r;
    logic         co;
    logic         ov;
    int           lat;
    logic         saw_vld;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sub = 1'b0; cin = 1'b0; dataa = '0; datab = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_result", result, 128'd0);
        check("rst_cout", {127'd0, cout}, 128'd0);
        check("rst_overflow", {127'd0, overflow}, 128'd0);

        // All-ones + 1: carry through every slice
        run_op(1'b0, 1'b0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, r, co, ov, lat);
        check("add_wrap_res", r, 128'd0);
        check("add_wrap_cout", {127'd0, co}, 128'd1);
        check("add_wrap_ovf", {127'd0, ov}, 128'd0);
        check("add_wrap_lat", 128'(lat), 128'd5);
        check("idle_after_hs", {127'd0, in_ready}, 128'd1);

        run_op(1'b1, 1'b0, 128'd0, 128'd1, r, co, ov, lat);
        check("sub_borrow_res", r, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
        check("sub_borrow_cout", {127'd0, co}, 128'd0);
        check("sub_borrow_ovf", {127'd0, ov}, 128'd0);

        run_op(1'b0, 1'b0, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, r, co, ov, lat);
        check("add_sovf_res", r, 128'h80000000_00000000_00000000_00000000);
        check("add_sovf_cout", {127'd0, co}, 128'd0);
        check("add_sovf_ovf", {127'd0, ov}, 128'd1);

        run_op(1'b0, 1'b1, 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd0, r, co, ov, lat);
        check("add_cin_res", r, 128'h00000001_00000000_00000000_00000000);
        check("add_cin_cout", {127'd0, co}, 128'd0);

        run_op(1'b1, 1'b1, 128'd10, 128'd3, r, co, ov, lat);
        check("sub_bin_res", r, 128'd6);
        check("sub_bin_cout", {127'd0, co}, 128'd1);
        check("sub_bin_ovf", {127'd0, ov}, 128'd0);

        run_op(1'b1, 1'b0, 128'h80000000_00000000_00000000_00000000, 128'd1, r, co, ov, lat);
        check("sub_sovf_res", r, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
        check("sub_sovf_cout", {127'd0, co}, 128'd1);
        check("sub_sovf_ovf", {127'd0, ov}, 128'd1);

        // Backpressure: result held in DONE while new requests are ignored
        sub = 1'b0; cin = 1'b0; dataa = 128'd3; datab = 128'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_lat", 128'(lat), 128'd5);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            sub = i[0];
            cin = i[1];
            dataa = 128'(i * 1000 + 77);
            datab = 128'(i * 3 + 5);
            tick();
            check("bp_res", result, 128'd7);
            check("bp_vld", {127'd0, out_valid}, 128'd1);
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
            check("bp_cout", {127'd0, cout}, 128'd0);
        end
        sub = 1'b0; cin = 1'b0; dataa = 128'd100; datab = 128'd23;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_hs_vld", {127'd0, out_valid}, 128'd0);
        check("bp_hs_in_ready", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_next_res", result, 128'd123);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset at RUN slice 2 abandons the op and beats a simultaneous request
        sub = 1'b0; cin = 1'b0; dataa = 128'h11111111_22222222_33333333_44444444; datab = 128'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0; in_valid = 1'b1; dataa = 128'd1; datab = 128'd1;
        tick();
        reset_n = 1'b1; in_valid = 1'b0;
        check("rst_run_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_run_result", result, 128'd0);
        saw_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            saw_vld = saw_vld | out_valid;
            tick();
        end
        check("rst_run_no_vld", {127'd0, saw_vld}, 128'd0);
        run_op(1'b0, 1'b0, 128'd5, 128'd7, r, co, ov, lat);
        check("post_rst_res", r, 128'd12);
        check("post_rst_lat", 128'(lat), 128'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter WORD_W, default 32, the slice width in bits added per cycle.
REQ-002 SHALL have parameter NWORDS, default 4, the number of slices; operand width W = WORD_W*NWORDS, and NWORDS >= 2.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port sub  input  1  0 = dataa+datab+cin, 1 = dataa-datab-cin.
REQ-008 SHALL have port cin  input  1  carry-in for add, borrow-in for subtract.
REQ-009 SHALL have port dataa  input  W  first operand.
REQ-010 SHALL have port datab  input  W  second operand.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  W  sum or difference modulo 2^W.
REQ-014 SHALL have port cout  output  1  add: carry out of bit W-1; subtract: 1 = no borrow.
REQ-015 SHALL have port overflow  output  1  two's-complement signed overflow of the full-width operation.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-017 SHALL assert in_ready only in IDLE; a request is accepted when in_valid && in_ready at a rising edge.
REQ-018 SHALL on acceptance latch dataa, datab, sub and cin, set the slice index to 0 and the carry register to sub ? ~cin : cin, and enter RUN.
REQ-019 SHALL in RUN compute, once per cycle for slice k: {c, s} = a[k] + (sub ? ~b[k] : b[k]) + carry, at WORD_W+1 bits; then store s into result slice k, set carry = c, and increment k.
REQ-020 SHALL process slices in order from least significant (k=0) to most significant (k=NWORDS-1); the slice index SHALL NOT wrap within an operation.
REQ-021 SHALL on completing slice NWORDS-1 set cout = c and overflow = carry-into-MSB XOR c, and enter DONE.
REQ-022 SHALL give a latency of exactly NWORDS+1 cycles from the accepting edge to the first cycle with out_valid=1 (acceptance edge, NWORDS compute edges, out_valid visible after the last compute edge).
REQ-023 SHALL assert out_valid only in DONE, and hold result, cout and overflow stable while out_valid=1 && out_ready=0.
REQ-024 SHALL on out_valid && out_ready go to IDLE, with in_ready=1 in the following cycle; there is no same-cycle accept/complete overlap (throughput one operation per NWORDS+2 cycles).
REQ-025 SHALL ignore in_valid, dataa, datab, sub and cin while in RUN or DONE.
REQ-026 SHALL ignore out_ready while not in DONE.
REQ-027 SHALL contain no combinational path from in_valid or out_ready to any output.

Reset
REQ-028 SHALL on reset_n=0 at a rising edge enter IDLE and set out_valid=0, result=0, cout=0, overflow=0, carry=0 and slice index=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-029 SHALL on reset asserted mid-RUN or in DONE abandon the operation with no out_valid pulse; reset SHALL take priority over acceptance in the same cycle.

Verification
REQ-030 SHALL pass this scenario: add, dataa=2^128-1, datab=1, cin=0 -> result=0, cout=1, overflow=0, out_valid first seen 5 cycles after acceptance.
REQ-031 SHALL pass this scenario: sub, dataa=0, datab=1, cin=0 -> result=2^128-1, cout=0 (borrow), overflow=0.
REQ-032 SHALL pass this scenario: add, dataa=0x7FFF...F (2^127-1), datab=1, cin=0 -> result=0x8000...0, cout=0, overflow=1.
REQ-033 SHALL pass this scenario: add, dataa=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, datab=0, cin=1 -> result=0x00000001_00000000_00000000_00000000 (carry ripples across 3 slices), cout=0.
REQ-034 SHALL pass this scenario: out_ready held 0 for 10 cycles in DONE with in_valid=1 and changing operands -> outputs stable, in_ready=0, and the new request accepted only after the handshake.
REQ-035 SHALL pass this scenario: reset_n=0 for one cycle at RUN slice 2 -> no out_valid; the next request (add, 5+7, cin=0) returns result=12.
